chnlnk_frame_arb: RTL
=====================

# chnlnk_frame_arb

Round-robin arbiter that shares one channel-link serializer among NREQ frame builders (one per sample-max frame FSM) in the DCFEB readout path. Grants the link to one builder for an entire frame: header through last word. Releases it on that builder's last-word strobe or on a watchdog timeout, then enforces an inter-frame gap. All control registers are triplicated with majority voting, consistent with the other link-path FSMs.

## Interface
Parameters:
- NREQ, 4 — number of frame builders; 2..8.
- IDXW, 2 — width of GNT_IDX; equals ceil(log2(NREQ)).
- GAP_CYC, 2 — extra idle cycles between frames (0..15).
- TIMEOUT, 16'd1023 — maximum BUSY cycles before forced release; 16-bit, must be ≥ 1.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  link enable; when low, no new grants are issued.
- REQ  in  NREQ  per-builder request; bit i = builder i L1A buffer non-empty.
- LAST  in  NREQ  per-builder last-word strobe (one cycle).
- GNT  out  NREQ  one-hot grant, registered; drives each builder's buffer-empty input as ~(REQ[i] & GNT[i]).
- GNT_IDX  out  IDXW  index of the granted builder; holds its last value when idle.
- BUSY  out  1  high in BUSY state.
- TMO_ERR  out  1  one-cycle pulse on watchdog release.
- ARB_STATE  out  2  voted state code, for status readback.

## Operation
- States: IDLE=2'b00, BUSY=2'b01, GAP=2'b10. Code 2'b11 is illegal and recovers to IDLE on the next edge with all outputs 0.
- IDLE:
  - If EN=1 and REQ≠0, select the first set REQ bit searching upward from ptr, wrapping modulo NREQ.
  - On that edge: load GNT one-hot, load GNT_IDX, set ptr = (sel+1) mod NREQ, clear cnt, and go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - GNT is held while in BUSY.
  - cnt increments by 1 each cycle and saturates at 16'hFFFF.
  - If LAST[GNT_IDX]=1: clear GNT and cnt, go to GAP.
  - Else if cnt == TIMEOUT-1: clear GNT and cnt, pulse TMO_ERR, go to GAP.
  - REQ changes and LAST from non-granted bits are ignored.
  - EN falling does not abort the frame in progress.
- GAP:
  - cnt increments each cycle.
  - When cnt == GAP_CYC: clear cnt and go to IDLE.
  - GAP therefore occupies GAP_CYC+1 cycles.
- If LAST and the timeout condition occur in the same cycle, LAST wins and TMO_ERR stays 0.
- Triplication:
  - state, ptr, cnt, GNT, GNT_IDX and TMO_ERR each have three copies.
  - Next-state logic of each copy uses the voted values.
  - Outputs are the majority vote of the three copies.
  - A single corrupted copy is corrected on the next edge.
- Reset (async): state=IDLE, ptr=0, cnt=0, GNT=0, GNT_IDX=0, BUSY=0, TMO_ERR=0, ARB_STATE=00.
- Reset asserted mid-frame drops GNT immediately, without waiting for a clock edge.

## Timing
- REQ sampled high at edge k (state IDLE) → GNT and BUSY high from k+1.
- LAST[idx] sampled at edge n:
  - GNT and BUSY drop from n+1.
  - GAP spans n+1 .. n+1+GAP_CYC.
  - IDLE at n+2+GAP_CYC.
  - Earliest next GNT at n+3+GAP_CYC (n+5 with default GAP_CYC=2).
- Timeout: GNT is held for exactly TIMEOUT cycles. TMO_ERR is high in the first GAP cycle, coincident with GNT falling.
- Minimum grant-to-grant spacing = frame length + GAP_CYC + 2 cycles.
- Outputs are all registered; there are no combinational paths from REQ or LAST to GNT.

## Test plan
- Single requester: REQ=4'b0001 steady, LAST[0] pulsed 100 cycles after grant.
  - Required: GNT=0001 one cycle after REQ; GNT low the cycle after LAST; next GNT exactly 5 cycles after LAST; TMO_ERR never asserts.
- Round-robin fairness: REQ=4'b1111 steady, each frame ends with LAST after 10 cycles.
  - Required: GNT_IDX sequence 0,1,2,3,0,…; no builder is granted twice consecutively.
- Wrap and skip: ptr=3, REQ=4'b0101.
  - Required: grant to 0, then 2, then 0; LAST[1] pulsed while granted to 0 is ignored.
- Watchdog: TIMEOUT=20, grant to builder 2, LAST never asserted.
  - Required: GNT held exactly 20 cycles; TMO_ERR a single one-cycle pulse; arbiter then grants the next requester.
- Simultaneous events and enable:
  - LAST in the same cycle as the timeout → TMO_ERR=0.
  - EN dropped mid-BUSY → frame completes, then no grant while EN=0.
- Reset and SEU:
  - RST mid-BUSY → GNT=0 asynchronously and state=IDLE.
  - Force state_2=11 during BUSY → voted ARB_STATE stays 01 and the copy is corrected next edge.

Source files
------------

// File: rtl/chnlnk_frame_arb.sv
// Round-robin arbiter granting the channel-link serializer to one frame builder per frame.
// Control state is held in three copies; every output and next-state decision uses the majority vote.
module chnlnk_frame_arb #(
  parameter int          NREQ    = 4,
  parameter int          IDXW    = 2,
  parameter int          GAP_CYC = 2,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] LAST,
  output logic [NREQ-1:0] GNT,
  output logic [IDXW-1:0] GNT_IDX,
  output logic            BUSY,
  output logic            TMO_ERR,
  output logic [1:0]      ARB_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_GAP  = 2'b10,
    ST_ILL  = 2'b11
  } arb_state_e;

  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);
  localparam logic [15:0]     GAP_END = 16'(GAP_CYC);
  localparam logic [15:0]     TMO_END = TIMEOUT - 16'd1;

  // Three register copies of every control item.
  logic [1:0]      state0_q, state1_q, state2_q;
  logic [IDXW-1:0] ptr_q  [3];
  logic [15:0]     cnt_q  [3];
  logic [NREQ-1:0] gnt_q  [3];
  logic [IDXW-1:0] idx_q  [3];
  logic            tmo_q  [3];

  // Voted views.
  arb_state_e      st_v;
  logic [IDXW-1:0] ptr_v;
  logic [15:0]     cnt_v;
  logic [NREQ-1:0] gnt_v;
  logic [IDXW-1:0] idx_v;
  logic            tmo_v;

  // Shared next-state values; all three copies load the same value.
  arb_state_e      st_d;
  logic [IDXW-1:0] ptr_d;
  logic [15:0]     cnt_d;
  logic [NREQ-1:0] gnt_d;
  logic [IDXW-1:0] idx_d;
  logic            tmo_d;

  logic            req_hit;
  logic [IDXW-1:0] sel_idx;
  logic [IDXW-1:0] cand;
  logic [15:0]     cnt_inc;

  assign st_v  = arb_state_e'((state0_q & state1_q) | (state0_q & state2_q) | (state1_q & state2_q));
  assign ptr_v = (ptr_q[0] & ptr_q[1]) | (ptr_q[0] & ptr_q[2]) | (ptr_q[1] & ptr_q[2]);
  assign cnt_v = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
  assign gnt_v = (gnt_q[0] & gnt_q[1]) | (gnt_q[0] & gnt_q[2]) | (gnt_q[1] & gnt_q[2]);
  assign idx_v = (idx_q[0] & idx_q[1]) | (idx_q[0] & idx_q[2]) | (idx_q[1] & idx_q[2]);
  assign tmo_v = (tmo_q[0] & tmo_q[1]) | (tmo_q[0] & tmo_q[2]) | (tmo_q[1] & tmo_q[2]);

  assign cnt_inc = (cnt_v == 16'hFFFF) ? cnt_v : cnt_v + 16'd1;

  // Scan downward in offset so the candidate closest to ptr is the one left standing.
  always_comb begin
    req_hit = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IDXW'((int'(ptr_v) + off) % NREQ);
      if (REQ[cand]) begin
        req_hit = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    st_d  = st_v;
    ptr_d = ptr_v;
    cnt_d = cnt_v;
    gnt_d = gnt_v;
    idx_d = idx_v;
    tmo_d = 1'b0;
    case (st_v)
      ST_IDLE: begin
        gnt_d = '0;
        if (EN && req_hit) begin
          gnt_d = GNT_ONE << sel_idx;
          idx_d = sel_idx;
          ptr_d = IDXW'((int'(sel_idx) + 1) % NREQ);
          cnt_d = '0;
          st_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_inc;
        // LAST is checked first so a coincident timeout never flags an error.
        if (LAST[idx_v]) begin
          gnt_d = '0;
          cnt_d = '0;
          st_d  = ST_GAP;
        end else if (cnt_v == TMO_END) begin
          gnt_d = '0;
          cnt_d = '0;
          tmo_d = 1'b1;
          st_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        gnt_d = '0;
        if (cnt_v == GAP_END) begin
          cnt_d = '0;
          st_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
        gnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state0_q <= ST_IDLE;
      state1_q <= ST_IDLE;
      state2_q <= ST_IDLE;
      for (int c = 0; c < 3; c++) begin
        ptr_q[c] <= '0;
        cnt_q[c] <= '0;
        gnt_q[c] <= '0;
        idx_q[c] <= '0;
        tmo_q[c] <= 1'b0;
      end
    end else begin
      state0_q <= st_d;
      state1_q <= st_d;
      state2_q <= st_d;
      for (int c = 0; c < 3; c++) begin
        ptr_q[c] <= ptr_d;
        cnt_q[c] <= cnt_d;
        gnt_q[c] <= gnt_d;
        idx_q[c] <= idx_d;
        tmo_q[c] <= tmo_d;
      end
    end
  end

  // Grant and error outputs are qualified by the voted state so an illegal code shows all zeros.
  assign BUSY      = (st_v == ST_BUSY);
  assign GNT       = BUSY ? gnt_v : '0;
  assign GNT_IDX   = idx_v;
  assign TMO_ERR   = (st_v == ST_GAP) && tmo_v;
  assign ARB_STATE = st_v;

endmodule
